n64_sync_gen: RTL and testbench
===============================

N64_SYNC_GEN -- requirements
Module: n64_sync_gen

Interface
REQ-001 Parameters: H_TOTAL_NTSC default 773, number of 4-VCLK slots per NTSC line; H_TOTAL_PAL default 794, slots per PAL line; HS_LEN default 57, hsync slots; CLAMP_LEN default 32, clamp slots; VS_LINES default 3, vsync length in lines.
REQ-002 VCLK  in  1  video clock.
REQ-003 nRST  in  1  reset; asynchronous, active-low.
REQ-004 en_i  in  1  generator enable.
REQ-005 mode_i  in  2  requested mode {palmode, n64_480i}.
REQ-006 nVDSYNC  out  1  slot marker; low during phase 0 of each slot.
REQ-007 VD_o  out  7  multiplexed video bus.
REQ-008 Sync_o  out  4  current sync nibble {nVSYNC, nCLAMP, nHSYNC, nCSYNC}.
REQ-009 vinfo_o  out  2  mode active in the current frame {palmode, n64_480i}.
REQ-010 field_o  out  1  1 = first field (vsync aligned to hsync), 0 = second field.

Function
REQ-011 2-bit phase counter SHALL advance every VCLK; slot counter hcnt SHALL advance when phase wraps 3->0 and SHALL wrap at H_TOTAL-1, then increment line counter vcnt.
REQ-012 H_TOTAL SHALL be H_TOTAL_PAL when active palmode=1, else H_TOTAL_NTSC; line total: progressive 263 NTSC / 313 PAL; interlaced frame 525 NTSC / 625 PAL.
REQ-013 mode_i SHALL be latched into vinfo_o only at frame start (vcnt=0, hcnt=0, phase=0); mid-frame changes SHALL NOT alter current-frame timing.
REQ-014 nHSYNC SHALL be low for hcnt in [0, HS_LEN-1]; nCLAMP SHALL be low for hcnt in [HS_LEN, HS_LEN+CLAMP_LEN-1].
REQ-015 Vsync assertion points: line 0 hcnt 0 (field_o=1); in interlaced mode additionally line 262 (NTSC) or line 312 (PAL) at hcnt = H_TOTAL/2 (integer divide, field_o=0); progressive: only line 0, field_o always 1.
REQ-016 nVSYNC SHALL stay low for VS_LINES*H_TOTAL slots from each assertion point.
REQ-017 nCSYNC = nHSYNC AND nVSYNC.
REQ-018 Sync_o and the sync nibble SHALL update only at phase 0 and hold for 4 cycles.
REQ-019 VD_o per phase: 0 -> {3'b000, Sync_o}; 1 -> hcnt[6:0]; 2 -> vcnt[6:0]; 3 -> hcnt[6:0] XOR 7'h7F.
REQ-020 Hsync negedges strictly between consecutive vsync negedges SHALL be 262 (NTSC) or 312 (PAL) in interlaced mode, and 262/312 in progressive mode (vsync coincides with hsync).
REQ-021 All outputs registered; nVDSYNC low exactly one cycle in four, coincident with sync nibble on VD_o.
REQ-022 en_i=0: counters held at 0, nVDSYNC=1, Sync_o=4'hF, VD_o=0; rising en_i SHALL start at frame start on the next VCLK.

Reset
REQ-023 On nRST low: phase, hcnt, vcnt = 0; nVDSYNC=1; Sync_o=4'hF; VD_o=7'h00; vinfo_o=2'b00; field_o=1.
REQ-024 Reset assertion mid-frame SHALL abort immediately; after release the first enabled VCLK SHALL emit phase 0 of line 0 with freshly latched mode_i.

Structure
REQ-025 H_TOTAL_*, line totals, HS_LEN, CLAMP_LEN, VS_LINES SHALL reside in the shared n64adv_vparams header.
REQ-026 One sub-module n64_sync_timing (phase/hcnt/vcnt counters, sync decode); top level holds mode latch and VD_o mux.

Verification
REQ-027 Reset release, en_i=1, mode_i=00 -> nVDSYNC pattern 0,1,1,1 repeating; hsync period 3092 VCLK; 262 hsync negedges between vsync negedges; field_o always 1.
REQ-028 mode_i=11 -> hsync period 3176 VCLK; vsync negedges alternate aligned/mid-line; 312 hsync negedges per field; field_o toggles.
REQ-029 mode_i=01 -> second vsync at line 262 hcnt 386; receiver model decodes palmode=0, n64_480i=1.
REQ-030 mode_i changed 00->10 mid-frame -> vinfo_o stays 00 until next frame start, then 10.
REQ-031 nRST pulsed at line 100 -> outputs at reset values within same cycle; restart at line 0 with VD_o phase 0 = 7'h0? per sync state.
REQ-032 en_i dropped mid-line, raised 10 cycles later -> idle outputs while low; restart at frame start.

Source files
------------

// File: rtl/n64_sync_gen_pkg.sv
// Shared video timing constants and types for the N64 sync generator
// (the n64adv_vparams set: line lengths, line totals, sync widths).
`timescale 1ns/1ps
package n64_sync_gen_pkg;

   localparam int unsigned HCNT_W = 10;
   localparam int unsigned VCNT_W = 10;

   localparam int unsigned H_TOTAL_NTSC_DEF = 773;
   localparam int unsigned H_TOTAL_PAL_DEF  = 794;
   localparam int unsigned HS_LEN_DEF       = 57;
   localparam int unsigned CLAMP_LEN_DEF    = 32;
   localparam int unsigned VS_LINES_DEF     = 3;

   localparam int unsigned V_TOTAL_NTSC_P = 263;
   localparam int unsigned V_TOTAL_PAL_P  = 313;
   localparam int unsigned V_TOTAL_NTSC_I = 525;
   localparam int unsigned V_TOTAL_PAL_I  = 625;

   // Line on which the half-line vsync of the second field starts
   localparam int unsigned VS2_LINE_NTSC = V_TOTAL_NTSC_P - 1;
   localparam int unsigned VS2_LINE_PAL  = V_TOTAL_PAL_P - 1;

   typedef enum logic [1:0] {
      PH_SYNC = 2'd0,
      PH_HCNT = 2'd1,
      PH_VCNT = 2'd2,
      PH_HINV = 2'd3
   } phase_e;

   typedef struct packed {
      logic palmode;
      logic n64_480i;
   } vmode_t;

   typedef struct packed {
      logic nvsync;
      logic nclamp;
      logic nhsync;
      logic ncsync;
   } sync_t;

endpackage

// File: rtl/n64_sync_timing.sv
// Phase/slot/line counters and combinational sync decode for the
// position currently being emitted.
`timescale 1ns/1ps
module n64_sync_timing
   import n64_sync_gen_pkg::*;
#(
   parameter int unsigned H_TOTAL_NTSC = H_TOTAL_NTSC_DEF,
   parameter int unsigned H_TOTAL_PAL  = H_TOTAL_PAL_DEF,
   parameter int unsigned HS_LEN       = HS_LEN_DEF,
   parameter int unsigned CLAMP_LEN    = CLAMP_LEN_DEF,
   parameter int unsigned VS_LINES     = VS_LINES_DEF
) (
   input  logic              VCLK,
   input  logic              nRST,
   input  logic              en_i,
   input  vmode_t            mode,
   output phase_e            phase,
   output logic [HCNT_W-1:0] hcnt,
   output logic [VCNT_W-1:0] vcnt,
   output sync_t             sync,
   output logic              vs_first,
   output logic              vs_second
);

   localparam logic [HCNT_W-1:0] H_NTSC    = HCNT_W'(H_TOTAL_NTSC);
   localparam logic [HCNT_W-1:0] H_PAL     = HCNT_W'(H_TOTAL_PAL);
   localparam logic [HCNT_W-1:0] HS_END    = HCNT_W'(HS_LEN);
   localparam logic [HCNT_W-1:0] CLAMP_END = HCNT_W'(HS_LEN + CLAMP_LEN);
   localparam logic [VCNT_W-1:0] VS_L      = VCNT_W'(VS_LINES);
   localparam logic [VCNT_W-1:0] VT_NP     = VCNT_W'(V_TOTAL_NTSC_P);
   localparam logic [VCNT_W-1:0] VT_PP     = VCNT_W'(V_TOTAL_PAL_P);
   localparam logic [VCNT_W-1:0] VT_NI     = VCNT_W'(V_TOTAL_NTSC_I);
   localparam logic [VCNT_W-1:0] VT_PI     = VCNT_W'(V_TOTAL_PAL_I);
   localparam logic [VCNT_W-1:0] VS2_N     = VCNT_W'(VS2_LINE_NTSC);
   localparam logic [VCNT_W-1:0] VS2_P     = VCNT_W'(VS2_LINE_PAL);

   logic [HCNT_W-1:0] h_total, h_half;
   logic [VCNT_W-1:0] v_total, vs2_line, vs2_off;
   logic              vs1_act, vs2_act, nhsync, nvsync;

   // Vsync spans VS_LINES full lines from its start point, so the
   // half-line variant is decoded as partial/full/partial lines.
   always_comb begin
      h_total  = mode.palmode ? H_PAL : H_NTSC;
      h_half   = h_total >> 1;
      v_total  = mode.palmode ? (mode.n64_480i ? VT_PI : VT_PP)
                              : (mode.n64_480i ? VT_NI : VT_NP);
      vs2_line = mode.palmode ? VS2_P : VS2_N;
      vs2_off  = vcnt - vs2_line;
      nhsync   = hcnt >= HS_END;
      vs1_act  = vcnt < VS_L;
      vs2_act  = mode.n64_480i && (vcnt >= vs2_line) &&
                 (((vs2_off == '0) && (hcnt >= h_half)) ||
                  ((vs2_off != '0) && (vs2_off < VS_L)) ||
                  ((vs2_off == VS_L) && (hcnt < h_half)));
      nvsync   = !(vs1_act || vs2_act);

      sync.nvsync = nvsync;
      sync.nclamp = (hcnt < HS_END) || (hcnt >= CLAMP_END);
      sync.nhsync = nhsync;
      sync.ncsync = nhsync && nvsync;

      vs_first  = (vcnt == '0) && (hcnt == '0);
      vs_second = mode.n64_480i && (vcnt == vs2_line) && (hcnt == h_half);
   end

   always_ff @(posedge VCLK or negedge nRST) begin
      if (!nRST) begin
         phase <= PH_SYNC;
         hcnt  <= '0;
         vcnt  <= '0;
      end else if (!en_i) begin
         phase <= PH_SYNC;
         hcnt  <= '0;
         vcnt  <= '0;
      end else begin
         phase <= phase_e'(phase + 2'd1);
         if (phase == PH_HINV) begin
            if (hcnt == h_total - 1'b1) begin
               hcnt <= '0;
               vcnt <= (vcnt == v_total - 1'b1) ? '0 : vcnt + 1'b1;
            end else begin
               hcnt <= hcnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/n64_sync_gen.sv
// N64 video sync generator: per-frame mode latch, registered sync nibble
// and the 4-phase multiplexed VD bus.
`timescale 1ns/1ps
module n64_sync_gen
   import n64_sync_gen_pkg::*;
#(
   parameter int unsigned H_TOTAL_NTSC = H_TOTAL_NTSC_DEF,
   parameter int unsigned H_TOTAL_PAL  = H_TOTAL_PAL_DEF,
   parameter int unsigned HS_LEN       = HS_LEN_DEF,
   parameter int unsigned CLAMP_LEN    = CLAMP_LEN_DEF,
   parameter int unsigned VS_LINES     = VS_LINES_DEF
) (
   input  logic       VCLK,
   input  logic       nRST,
   input  logic       en_i,
   input  logic [1:0] mode_i,
   output logic       nVDSYNC,
   output logic [6:0] VD_o,
   output logic [3:0] Sync_o,
   output logic [1:0] vinfo_o,
   output logic       field_o
);

   phase_e            phase;
   logic [HCNT_W-1:0] hcnt;
   logic [VCNT_W-1:0] vcnt;
   sync_t             sync;
   logic              vs_first, vs_second, frame_start;
   vmode_t            active_mode;

   // At the frame-start position the new mode already governs timing;
   // everywhere else the latched copy does.
   always_comb begin
      frame_start = (phase == PH_SYNC) && (hcnt == '0) && (vcnt == '0);
      active_mode = frame_start ? vmode_t'(mode_i) : vmode_t'(vinfo_o);
   end

   n64_sync_timing #(
      .H_TOTAL_NTSC (H_TOTAL_NTSC),
      .H_TOTAL_PAL  (H_TOTAL_PAL),
      .HS_LEN       (HS_LEN),
      .CLAMP_LEN    (CLAMP_LEN),
      .VS_LINES     (VS_LINES)
   ) u_timing (
      .VCLK      (VCLK),
      .nRST      (nRST),
      .en_i      (en_i),
      .mode      (active_mode),
      .phase     (phase),
      .hcnt      (hcnt),
      .vcnt      (vcnt),
      .sync      (sync),
      .vs_first  (vs_first),
      .vs_second (vs_second)
   );

   always_ff @(posedge VCLK or negedge nRST) begin
      if (!nRST) begin
         nVDSYNC <= 1'b1;
         Sync_o  <= '1;
         VD_o    <= '0;
         vinfo_o <= '0;
         field_o <= 1'b1;
      end else if (!en_i) begin
         nVDSYNC <= 1'b1;
         Sync_o  <= '1;
         VD_o    <= '0;
         field_o <= 1'b1;
      end else begin
         nVDSYNC <= (phase != PH_SYNC);
         if (frame_start) vinfo_o <= mode_i;
         if (vs_first)       field_o <= 1'b1;
         else if (vs_second) field_o <= 1'b0;
         unique case (phase)
            PH_SYNC: begin
               Sync_o <= sync;
               VD_o   <= {3'b000, sync};
            end
            PH_HCNT: VD_o <= hcnt[6:0];
            PH_VCNT: VD_o <= vcnt[6:0];
            PH_HINV: VD_o <= hcnt[6:0] ^ 7'h7F;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_n64_sync_gen.sv
// Scoreboard bench for n64_sync_gen: expected vsync events are queued by
// the stimulus and checked by a VD-bus receiver as each vsync arrives.
`timescale 1ns/1ps
module tb_n64_sync_gen;

   logic       VCLK = 1'b0;
   logic       nRST;
   logic       en;
   logic [1:0] mode;

   logic       nVDSYNC, field_o;
   logic [6:0] VD_o;
   logic [3:0] Sync_o;
   logic [1:0] vinfo_o;

   logic       d_nvdsync, d_field;
   logic [6:0] d_vd;
   logic [3:0] d_sync;
   logic [1:0] d_vinfo;

   always #5 VCLK = ~VCLK;

   n64_sync_gen #(
      .H_TOTAL_NTSC (8),
      .H_TOTAL_PAL  (9),
      .HS_LEN       (2),
      .CLAMP_LEN    (2),
      .VS_LINES     (3)
   ) dut (
      .VCLK    (VCLK),
      .nRST    (nRST),
      .en_i    (en),
      .mode_i  (mode),
      .nVDSYNC (nVDSYNC),
      .VD_o    (VD_o),
      .Sync_o  (Sync_o),
      .vinfo_o (vinfo_o),
      .field_o (field_o)
   );

   n64_sync_gen u_def (
      .VCLK    (VCLK),
      .nRST    (nRST),
      .en_i    (en),
      .mode_i  (2'b00),
      .nVDSYNC (d_nvdsync),
      .VD_o    (d_vd),
      .Sync_o  (d_sync),
      .vinfo_o (d_vinfo),
      .field_o (d_field)
   );

   typedef struct {
      int         hs;
      int         vline;
      int         hpos;
      logic       fld;
      logic [1:0] vinfo;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;

   int exp_nvd[8] = '{0, 1, 1, 1, 0, 1, 1, 1};
   int exp_vd[8]  = '{4, 0, 0, 127, 4, 1, 0, 126};

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic expect_vs(input int hs, input int vline, input int hpos,
                            input logic fld, input logic [1:0] vi);
      exp_t x;
      x.hs = hs; x.vline = vline; x.hpos = hpos; x.fld = fld; x.vinfo = vi;
      sbq.push_back(x);
   endtask

   task automatic wait_drain(input int max_cyc, input string tag);
      int n = 0;
      while (sbq.size() != 0 && n < max_cyc) begin
         @(negedge VCLK);
         n++;
      end
      if (sbq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s: %0d vsync events still pending after %0d cycles, expected 0",
                  tag, sbq.size(), max_cyc);
         sbq.delete();
      end
   endtask

   task automatic start_run(input logic [1:0] m);
      @(negedge VCLK);
      nRST = 1'b0;
      en   = 1'b1;
      mode = m;
      repeat (2) @(negedge VCLK);
   endtask

   // Receiver: rebuilds each 4-word slot from VD_o and scores vsync events
   int         cyc = 0, slot = 4, hs_cnt = 0, hs_period = 0, last_hs = 0;
   int         mon_vline = -1;
   bit         have_hs = 0;
   logic [3:0] prev_sync = 4'hF;
   logic [6:0] w[4];
   logic       cap_field;
   logic [1:0] cap_vinfo;

   always @(negedge VCLK) begin
      cyc++;
      if (!nRST || !en) begin
         slot = 4; hs_cnt = 0; prev_sync = 4'hF; have_hs = 0;
      end else begin
         if (!nVDSYNC) begin
            slot = 0; cap_field = field_o; cap_vinfo = vinfo_o;
         end else if (slot < 4) begin
            slot++;
         end
         if (slot < 4) w[slot] = VD_o;
         if (slot == 3) begin
            mon_vline = int'(w[2]);
            if (prev_sync[1] && !w[0][1]) begin
               if (have_hs) hs_period = cyc - last_hs;
               last_hs = cyc;
               have_hs = 1;
            end
            if (prev_sync[3] && !w[0][3]) begin
               if (sbq.size() > 0) begin
                  e = sbq.pop_front();
                  if (e.hs >= 0) check("vs_hsyncs_between", hs_cnt, e.hs);
                  check("vs_line", int'(w[2]), e.vline);
                  check("vs_hpos", int'(w[1]), e.hpos);
                  check("vs_hpos_inv", int'(w[3]), e.hpos ^ 127);
                  check("vs_field", int'(cap_field), int'(e.fld));
                  check("vs_vinfo", int'(cap_vinfo), int'(e.vinfo));
               end
               hs_cnt = 0;
            end else if (prev_sync[1] && !w[0][1]) begin
               hs_cnt++;
            end
            prev_sync = w[0][3:0];
         end
      end
   end

   int d_cyc = 0, d_last = 0, d_period = 0;
   bit d_have = 0;
   logic d_prev = 1'b1;

   always @(negedge VCLK) begin
      d_cyc++;
      if (!nRST || !en) begin
         d_prev = 1'b1; d_have = 0;
      end else begin
         if (d_prev && !d_sync[1]) begin
            if (d_have) d_period = d_cyc - d_last;
            d_last = d_cyc;
            d_have = 1;
         end
         d_prev = d_sync[1];
      end
   end

   initial begin
      nRST = 1'b1; en = 1'b1; mode = 2'b00;
      #2 nRST = 1'b0;

      // Progressive NTSC
      start_run(2'b00);
      check("rst_nVDSYNC", int'(nVDSYNC), 1);
      check("rst_Sync", int'(Sync_o), 15);
      check("rst_VD", int'(VD_o), 0);
      check("rst_vinfo", int'(vinfo_o), 0);
      check("rst_field", int'(field_o), 1);
      check("rst_def_nVDSYNC", int'(d_nvdsync), 1);
      check("rst_def_VD", int'(d_vd), 0);
      check("rst_def_vinfo", int'(d_vinfo), 0);
      check("rst_def_field", int'(d_field), 1);
      expect_vs(0, 0, 0, 1'b1, 2'b00);
      expect_vs(262, 0, 0, 1'b1, 2'b00);
      nRST = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge VCLK);
         check("first_nVDSYNC", int'(nVDSYNC), exp_nvd[i]);
         check("first_VD", int'(VD_o), exp_vd[i]);
         if (i == 0) check("first_Sync", int'(Sync_o), 4);
      end
      wait_drain(9000, "ntsc_p");
      check("ntsc_hs_period", hs_period, 32);
      check("default_hs_period", d_period, 3092);

      // Interlaced PAL
      start_run(2'b11);
      expect_vs(0, 0, 0, 1'b1, 2'b11);
      expect_vs(312, 312 % 128, 4, 1'b0, 2'b11);
      expect_vs(312, 0, 0, 1'b1, 2'b11);
      nRST = 1'b1;
      wait_drain(23500, "pal_i");
      check("pal_hs_period", hs_period, 36);

      // Interlaced NTSC
      start_run(2'b01);
      expect_vs(0, 0, 0, 1'b1, 2'b01);
      expect_vs(262, 262 % 128, 4, 1'b0, 2'b01);
      nRST = 1'b1;
      wait_drain(9000, "ntsc_i");

      // Mid-frame mode change only takes effect at the next frame
      start_run(2'b00);
      expect_vs(0, 0, 0, 1'b1, 2'b00);
      expect_vs(262, 0, 0, 1'b1, 2'b10);
      expect_vs(312, 0, 0, 1'b1, 2'b10);
      nRST = 1'b1;
      repeat (3200) @(negedge VCLK);
      mode = 2'b10;
      repeat (2) begin
         @(negedge VCLK);
         check("midframe_vinfo", int'(vinfo_o), 0);
      end
      wait_drain(21000, "mode_change");

      // Reset pulse at line 100
      start_run(2'b00);
      expect_vs(0, 0, 0, 1'b1, 2'b00);
      nRST = 1'b1;
      begin
         int n = 0;
         while (!(mon_vline == 100 && sbq.size() == 0) && n < 5000) begin
            @(negedge VCLK);
            n++;
         end
      end
      check("reach_line100", mon_vline, 100);
      check("reach_line100_drained", sbq.size(), 0);
      nRST = 1'b0;
      #1;
      check("arst_nVDSYNC", int'(nVDSYNC), 1);
      check("arst_Sync", int'(Sync_o), 15);
      check("arst_VD", int'(VD_o), 0);
      check("arst_vinfo", int'(vinfo_o), 0);
      check("arst_field", int'(field_o), 1);
      mode = 2'b01;
      expect_vs(0, 0, 0, 1'b1, 2'b01);
      @(negedge VCLK);
      nRST = 1'b1;
      @(negedge VCLK);
      check("restart_nVDSYNC", int'(nVDSYNC), 0);
      check("restart_VD", int'(VD_o), 4);
      check("restart_vinfo", int'(vinfo_o), 1);
      wait_drain(100, "restart");

      // Enable dropped mid-line for 10 cycles
      repeat (50) @(negedge VCLK);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge VCLK);
         check("idle_nVDSYNC", int'(nVDSYNC), 1);
         check("idle_Sync", int'(Sync_o), 15);
         check("idle_VD", int'(VD_o), 0);
      end
      expect_vs(0, 0, 0, 1'b1, 2'b01);
      en = 1'b1;
      @(negedge VCLK);
      check("reen_nVDSYNC", int'(nVDSYNC), 0);
      check("reen_VD", int'(VD_o), 4);
      wait_drain(100, "reenable");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
